// File: rtl/dff_delay_line_param.sv
// WIDTH x DEPTH register delay line with a runtime-selected output tap, stall
// enable, synchronous flush, per-stage valid bits and a running valid count.
module dff_delay_line_param #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter int SEL_W = $clog2(DEPTH),
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             enable,
  input  logic             flush,
  input  logic [WIDTH-1:0] input_data,
  input  logic             input_valid,
  input  logic [SEL_W-1:0] delay_sel,
  output logic [WIDTH-1:0] output_data,
  output logic             output_valid,
  output logic [CNT_W-1:0] fill_count
);

  logic [DEPTH-1:0][WIDTH-1:0] data_q;
  logic [DEPTH-1:0]            valid_q;
  logic [CNT_W-1:0]            count_q;
  logic [CNT_W-1:0]            count_next;
  logic [SEL_W-1:0]            tap;

  // The count tracks entries in and out of the chain rather than re-counting
  // the valid bits, so it stays a short adder no matter how deep the line is.
  always_comb begin
    count_next = count_q;
    unique case ({input_valid, valid_q[DEPTH-1]})
      2'b10:   count_next = count_q + CNT_W'(1);
      2'b01:   count_next = count_q - CNT_W'(1);
      default: count_next = count_q;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      data_q  <= '0;
      valid_q <= '0;
      count_q <= '0;
    end else if (flush) begin
      data_q  <= '0;
      valid_q <= '0;
      count_q <= '0;
    end else if (enable) begin
      data_q  <= {data_q[DEPTH-2:0], input_data};
      valid_q <= {valid_q[DEPTH-2:0], input_valid};
      count_q <= count_next;
    end
  end

  // Out-of-range selects (non power-of-two DEPTH) fall back to the last stage.
  always_comb begin
    tap = delay_sel;
    if (int'(delay_sel) > DEPTH - 1)
      tap = SEL_W'(DEPTH - 1);
  end

  assign output_data  = data_q[tap];
  assign output_valid = valid_q[tap];
  assign fill_count   = count_q;

endmodule

// File: tb/tb_dff_delay_line_param.sv
// Directed bench for dff_delay_line_param: a vector table for the streaming,
// stall, flush and valid-count cases plus hand sequences for the tap mux,
// mid-cycle reset and the DEPTH=5 select clamp.
module tb_dff_delay_line_param;

  logic       clk;
  logic       rst_n;
  logic       enable;
  logic       flush;
  logic [7:0] in_data;
  logic       in_valid;
  logic [1:0] sel;
  logic [7:0] out_data;
  logic       out_valid;
  logic [2:0] count;

  logic       enable5;
  logic       flush5;
  logic [7:0] in_data5;
  logic       in_valid5;
  logic [2:0] sel5;
  logic [7:0] out_data5;
  logic       out_valid5;
  logic [2:0] count5;

  int tests_run;
  int tests_failed;

  typedef struct {
    logic       en;
    logic       fl;
    logic       iv;
    logic [7:0] id;
    logic [1:0] sel;
    logic [7:0] ed;
    logic       ev;
    logic [2:0] ec;
  } vec_t;

  vec_t vecs[26];

  dff_delay_line_param #(.WIDTH(8), .DEPTH(4)) dut (
    .CLK          (clk),
    .RST          (rst_n),
    .enable       (enable),
    .flush        (flush),
    .input_data   (in_data),
    .input_valid  (in_valid),
    .delay_sel    (sel),
    .output_data  (out_data),
    .output_valid (out_valid),
    .fill_count   (count)
  );

  dff_delay_line_param #(.WIDTH(8), .DEPTH(5)) dut5 (
    .CLK          (clk),
    .RST          (rst_n),
    .enable       (enable5),
    .flush        (flush5),
    .input_data   (in_data5),
    .input_valid  (in_valid5),
    .delay_sel    (sel5),
    .output_data  (out_data5),
    .output_valid (out_valid5),
    .fill_count   (count5)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string name, input int actual, input int expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic check_output(input string name, input logic [7:0] ed, input logic ev,
                              input logic [2:0] ec);
    check_val({name, " data"}, int'(out_data), int'(ed));
    check_val({name, " valid"}, int'(out_valid), int'(ev));
    check_val({name, " count"}, int'(count), int'(ec));
  endtask

  task automatic apply_stimulus(input logic en, input logic fl, input logic iv,
                                input logic [7:0] id, input logic [1:0] s);
    enable   = en;
    flush    = fl;
    in_valid = iv;
    in_data  = id;
    sel      = s;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [7:0] e5_data [6];
    logic       e5_valid[6];
    logic [7:0] x5_data [6];
    logic       x5_valid[6];
    logic [2:0] x5_count[6];

    tests_run    = 0;
    tests_failed = 0;
    rst_n        = 1'b0;
    apply_stimulus(1'b0, 1'b0, 1'b0, 8'h00, 2'd3);
    enable5   = 1'b0;
    flush5    = 1'b0;
    in_data5  = 8'h00;
    in_valid5 = 1'b0;
    sel5      = 3'd7;

    //            en    fl    iv    data   sel     exp_d  exp_v exp_cnt
    vecs[0]  = '{1'b1, 1'b0, 1'b1, 8'h11, 2'd3, 8'h00, 1'b0, 3'd1};
    vecs[1]  = '{1'b1, 1'b0, 1'b1, 8'h22, 2'd3, 8'h00, 1'b0, 3'd2};
    vecs[2]  = '{1'b1, 1'b0, 1'b1, 8'h33, 2'd3, 8'h00, 1'b0, 3'd3};
    vecs[3]  = '{1'b1, 1'b0, 1'b1, 8'h44, 2'd3, 8'h11, 1'b1, 3'd4};
    vecs[4]  = '{1'b1, 1'b0, 1'b1, 8'h55, 2'd3, 8'h22, 1'b1, 3'd4};
    vecs[5]  = '{1'b1, 1'b0, 1'b1, 8'h66, 2'd0, 8'h66, 1'b1, 3'd4};
    vecs[6]  = '{1'b0, 1'b0, 1'b1, 8'h77, 2'd2, 8'h44, 1'b1, 3'd4};
    vecs[7]  = '{1'b1, 1'b1, 1'b1, 8'hFF, 2'd3, 8'h00, 1'b0, 3'd0};
    vecs[8]  = '{1'b1, 1'b0, 1'b1, 8'hA1, 2'd1, 8'h00, 1'b0, 3'd1};
    vecs[9]  = '{1'b1, 1'b0, 1'b1, 8'hA2, 2'd1, 8'hA1, 1'b1, 3'd2};
    for (int i = 10; i < 15; i++)
      vecs[i] = '{1'b0, 1'b0, 1'b1, 8'hBB, 2'd1, 8'hA1, 1'b1, 3'd2};
    vecs[15] = '{1'b1, 1'b0, 1'b1, 8'hA3, 2'd1, 8'hA2, 1'b1, 3'd3};
    vecs[16] = '{1'b1, 1'b0, 1'b1, 8'hA4, 2'd1, 8'hA3, 1'b1, 3'd4};
    vecs[17] = '{1'b1, 1'b0, 1'b0, 8'h00, 2'd3, 8'hA2, 1'b1, 3'd3};
    vecs[18] = '{1'b0, 1'b1, 1'b0, 8'h00, 2'd3, 8'h00, 1'b0, 3'd0};
    vecs[19] = '{1'b1, 1'b0, 1'b1, 8'h01, 2'd3, 8'h00, 1'b0, 3'd1};
    vecs[20] = '{1'b1, 1'b0, 1'b0, 8'h02, 2'd3, 8'h00, 1'b0, 3'd1};
    vecs[21] = '{1'b1, 1'b0, 1'b1, 8'h03, 2'd3, 8'h00, 1'b0, 3'd2};
    vecs[22] = '{1'b1, 1'b0, 1'b0, 8'h04, 2'd3, 8'h01, 1'b1, 3'd2};
    vecs[23] = '{1'b1, 1'b0, 1'b1, 8'h05, 2'd3, 8'h02, 1'b0, 3'd2};
    vecs[24] = '{1'b1, 1'b0, 1'b0, 8'h06, 2'd3, 8'h03, 1'b1, 3'd2};
    vecs[25] = '{1'b1, 1'b0, 1'b0, 8'h07, 2'd0, 8'h07, 1'b0, 3'd1};

    #12;
    check_output("reset", 8'h00, 1'b0, 3'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 26; i++) begin
      apply_stimulus(vecs[i].en, vecs[i].fl, vecs[i].iv, vecs[i].id, vecs[i].sel);
      tick();
      check_output($sformatf("vec%0d", i), vecs[i].ed, vecs[i].ev, vecs[i].ec);
    end

    // Tap changes take effect without a clock edge; contents stay [07,06,05,04].
    apply_stimulus(1'b0, 1'b0, 1'b1, 8'hEE, 2'd2);
    #1 check_output("tap2", 8'h05, 1'b1, 3'd1);
    sel = 2'd1;
    #1 check_output("tap1", 8'h06, 1'b0, 3'd1);
    sel = 2'd3;
    #1 check_output("tap3", 8'h04, 1'b0, 3'd1);
    tick();
    check_output("tap3_hold", 8'h04, 1'b0, 3'd1);

    // Part-fill, then pull reset between edges.
    apply_stimulus(1'b1, 1'b0, 1'b1, 8'hC1, 2'd1);
    tick();
    check_output("fill_c1", 8'h07, 1'b0, 3'd2);
    apply_stimulus(1'b1, 1'b0, 1'b1, 8'hC2, 2'd1);
    tick();
    check_output("fill_c2", 8'hC1, 1'b1, 3'd2);
    #2 rst_n = 1'b0;
    #1 check_output("async_rst", 8'h00, 1'b0, 3'd0);
    #2 rst_n = 1'b1;
    apply_stimulus(1'b1, 1'b0, 1'b1, 8'hD1, 2'd2);
    tick();
    check_output("post_rst1", 8'h00, 1'b0, 3'd1);
    in_data = 8'hD2;
    tick();
    check_output("post_rst2", 8'h00, 1'b0, 3'd2);
    in_data = 8'hD3;
    tick();
    check_output("post_rst3", 8'hD1, 1'b1, 3'd3);
    enable = 1'b0;

    // DEPTH=5 with delay_sel=7 clamps to stage 4, a five-edge delay.
    e5_data  = '{8'hE1, 8'hE2, 8'hE3, 8'hE4, 8'hE5, 8'hE6};
    e5_valid = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    x5_data  = '{8'h00, 8'h00, 8'h00, 8'h00, 8'hE1, 8'hE2};
    x5_valid = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    x5_count = '{3'd1, 3'd1, 3'd2, 3'd2, 3'd3, 3'd2};
    enable5 = 1'b1;
    sel5    = 3'd7;
    for (int i = 0; i < 6; i++) begin
      in_data5  = e5_data[i];
      in_valid5 = e5_valid[i];
      tick();
      check_val($sformatf("d5_step%0d data", i), int'(out_data5), int'(x5_data[i]));
      check_val($sformatf("d5_step%0d valid", i), int'(out_valid5), int'(x5_valid[i]));
      check_val($sformatf("d5_step%0d count", i), int'(count5), int'(x5_count[i]));
    end
    enable5 = 1'b0;
    sel5    = 3'd5;
    #1 check_val("d5_sel5 data", int'(out_data5), 32'hE2);
    sel5    = 3'd1;
    #1 check_val("d5_sel1 data", int'(out_data5), 32'hE5);
    check_val("d5_sel1 valid", int'(out_valid5), 1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
